// File: rtl/aes_key_pkg.sv
// Shared types and constants for the AES-128 key-schedule generator.
package aes_key_pkg;

  localparam int NK = 4;
  localparam int NB = 4;

  typedef enum logic [4:0] {
    IDLE = 5'b00001,
    KEY  = 5'b00010,
    SUB  = 5'b00100,
    WR   = 5'b01000,
    FIN  = 5'b10000
  } state_t;

  localparam logic [7:0] RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

endpackage

// File: rtl/aes_key_expand_sbox.sv
// AES forward S-box as a single-port 256x8 ROM with a registered output.
module aes_key_expand_sbox (
  input  logic       clk,
  input  logic       ce,
  input  logic [7:0] addr,
  output logic [7:0] q
);

  localparam logic [7:0] ROM [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  always_ff @(posedge clk) begin
    if (ce) q <= ROM[addr];
  end

endmodule

// File: rtl/aes_key_expand.sv
// AES-128 key expansion: reads the cipher key byte-wise and writes all 44
// schedule columns into the row-major round-key table, one byte per cycle.
module aes_key_expand
  import aes_key_pkg::*;
#(
  parameter int WORD_STRIDE = 120,
  parameter int NCOL        = 44
) (
  input  logic        ap_clk,
  input  logic        ap_rst,
  input  logic        ap_start,
  output logic        ap_done,
  output logic        ap_idle,
  output logic        ap_ready,
  output logic [3:0]  key_address0,
  output logic        key_ce0,
  input  logic [31:0] key_q0,
  output logic [8:0]  word_address0,
  output logic        word_ce0,
  output logic        word_we0,
  output logic [7:0]  word_d0
);

  state_t     state_reg, state_next;
  logic [4:0] k_reg;
  logic [2:0] s_reg;
  logic [1:0] i_reg;
  logic [5:0] j_reg;
  // window_reg[c] holds column j-4+c; window_reg[3] is the newest column.
  logic [7:0] window_reg [NB][4];
  logic [7:0] temp_reg [4];
  logic [7:0] new_col [4];

  logic       sbox_ce;
  logic [7:0] sbox_addr;
  logic [7:0] sbox_q;
  logic [3:0] key_byte;
  logic [1:0] rot_idx;
  logic [1:0] s_prev;
  logic [3:0] rcon_idx;
  logic       key_hi_unused;

  assign key_byte      = k_reg[3:0] - 4'd1;
  assign rot_idx       = s_reg[1:0] + 2'd1;
  assign s_prev        = s_reg[1:0] - 2'd1;
  assign rcon_idx      = j_reg[5:2] - 4'd1;
  assign key_hi_unused = ^key_q0[31:8];

  function automatic logic [8:0] tbl_addr(input logic [1:0] row, input logic [5:0] col);
    return 9'(row) * 9'(WORD_STRIDE) + 9'(col);
  endfunction

  for (genvar gi = 0; gi < 4; gi++) begin : g_col
    assign new_col[gi] = window_reg[0][gi] ^
                         ((j_reg[1:0] == 2'd0) ? temp_reg[gi] : window_reg[3][gi]);
  end

  aes_key_expand_sbox u_sbox (
    .clk  (ap_clk),
    .ce   (sbox_ce),
    .addr (sbox_addr),
    .q    (sbox_q)
  );

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (ap_start) state_next = KEY;
      KEY:  if (k_reg == 5'd16) state_next = SUB;
      SUB:  if (s_reg == 3'd4) state_next = WR;
      WR: begin
        if (i_reg == 2'd3) begin
          if (j_reg == 6'(NCOL - 1))   state_next = FIN;
          else if (j_reg[1:0] == 2'd3) state_next = SUB;
          else                         state_next = WR;
        end
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ap_idle       = 1'b0;
    ap_done       = 1'b0;
    ap_ready      = 1'b0;
    key_ce0       = 1'b0;
    key_address0  = '0;
    word_ce0      = 1'b0;
    word_we0      = 1'b0;
    word_address0 = '0;
    word_d0       = '0;
    sbox_ce       = 1'b0;
    sbox_addr     = '0;
    case (state_reg)
      IDLE: ap_idle = 1'b1;
      KEY: begin
        if (k_reg < 5'd16) begin
          key_ce0      = 1'b1;
          key_address0 = k_reg[3:0];
        end
        // Key data lags its read by a cycle, so byte k-1 is written now.
        if (k_reg != 5'd0) begin
          word_ce0      = 1'b1;
          word_we0      = 1'b1;
          word_address0 = tbl_addr(key_byte[1:0], {4'd0, key_byte[3:2]});
          word_d0       = key_q0[7:0];
        end
      end
      SUB: begin
        if (s_reg < 3'd4) begin
          sbox_ce   = 1'b1;
          sbox_addr = window_reg[3][rot_idx];
        end
      end
      WR: begin
        word_ce0      = 1'b1;
        word_we0      = 1'b1;
        word_address0 = tbl_addr(i_reg, j_reg);
        word_d0       = new_col[i_reg];
      end
      FIN: begin
        ap_done  = 1'b1;
        ap_ready = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      k_reg <= '0;
      s_reg <= '0;
      i_reg <= '0;
      j_reg <= '0;
      for (int c = 0; c < NB; c++)
        for (int r = 0; r < 4; r++)
          window_reg[c][r] <= '0;
      for (int r = 0; r < 4; r++)
        temp_reg[r] <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          k_reg <= '0;
          s_reg <= '0;
          i_reg <= '0;
          j_reg <= '0;
        end
        KEY: begin
          if (k_reg != 5'd0)
            window_reg[key_byte[3:2]][key_byte[1:0]] <= key_q0[7:0];
          if (k_reg == 5'd16) begin
            k_reg <= '0;
            j_reg <= 6'(NK);
          end else begin
            k_reg <= k_reg + 5'd1;
          end
        end
        SUB: begin
          // S-box output trails its address by one cycle.
          if (s_reg != 3'd0) temp_reg[s_prev] <= sbox_q;
          if (s_reg == 3'd4) begin
            temp_reg[0] <= temp_reg[0] ^ RCON[rcon_idx];
            s_reg       <= '0;
          end else begin
            s_reg <= s_reg + 3'd1;
          end
        end
        WR: begin
          i_reg <= i_reg + 2'd1;
          if (i_reg == 2'd3) begin
            for (int c = 0; c < NB - 1; c++)
              for (int r = 0; r < 4; r++)
                window_reg[c][r] <= window_reg[c + 1][r];
            for (int r = 0; r < 4; r++)
              window_reg[NB - 1][r] <= new_col[r];
            j_reg <= j_reg + 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_key_expand.sv
// Bench for aes_key_expand: key/table memory models, a run scoreboard and
// known-answer table vectors for the FIPS-197 and all-zero keys.
module tb_aes_key_expand;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic        ap_start;
  logic        ap_done, ap_idle, ap_ready;
  logic [3:0]  key_address0;
  logic        key_ce0;
  logic [31:0] key_q0;
  logic [8:0]  word_address0;
  logic        word_ce0, word_we0;
  logic [7:0]  word_d0;

  aes_key_expand dut (
    .ap_clk        (ap_clk),
    .ap_rst        (ap_rst),
    .ap_start      (ap_start),
    .ap_done       (ap_done),
    .ap_idle       (ap_idle),
    .ap_ready      (ap_ready),
    .key_address0  (key_address0),
    .key_ce0       (key_ce0),
    .key_q0        (key_q0),
    .word_address0 (word_address0),
    .word_ce0      (word_ce0),
    .word_we0      (word_we0),
    .word_d0       (word_d0)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct { int key_id; logic [8:0] addr; logic [7:0] exp; } vec_t;
  typedef struct { int cyc; int key_id; } run_t;

  vec_t        vecs[$];
  run_t        exp_q[$];
  logic [7:0]  keys [2][16];
  logic [7:0]  key_mem [16];
  logic [23:0] hi_junk = '0;
  logic [7:0]  tbl [512];
  logic        written [512];
  int          wr_count = 0, dup_count = 0, bad_count = 0, ecnt = 0;
  logic        clr = 1'b0;
  int          n_vec = 0, n_bad = 0;

  // Key ROM with one-cycle read latency plus the round-key table recorder.
  always @(posedge ap_clk) begin
    ecnt <= ecnt + 1;
    if (key_ce0) key_q0 <= {hi_junk, key_mem[key_address0]};
    if (clr) begin
      for (int a = 0; a < 512; a++) begin
        tbl[a]     <= 'x;
        written[a] <= 1'b0;
      end
      wr_count  <= 0;
      dup_count <= 0;
      bad_count <= 0;
    end else if (word_ce0 && word_we0) begin
      tbl[word_address0]     <= word_d0;
      written[word_address0] <= 1'b1;
      wr_count <= wr_count + 1;
      if (written[word_address0]) dup_count <= dup_count + 1;
      if (word_address0 >= 9'd480 || (word_address0 % 9'd120) >= 9'd44)
        bad_count <= bad_count + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic void add_vec(input int id, input int addr, input logic [7:0] val);
    vec_t v;
    v.key_id = id;
    v.addr   = 9'(addr);
    v.exp    = val;
    vecs.push_back(v);
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ap_idle"}, ap_idle, 1);
    check({tag, "_ap_done"}, ap_done, 0);
    check({tag, "_ap_ready"}, ap_ready, 0);
    check({tag, "_key_ce0"}, key_ce0, 0);
    check({tag, "_key_addr"}, key_address0, 0);
    check({tag, "_word_ce0"}, word_ce0, 0);
    check({tag, "_word_we0"}, word_we0, 0);
    check({tag, "_word_addr"}, word_address0, 0);
    check({tag, "_word_d0"}, word_d0, 0);
  endtask

  // Clears the table, raises start at a negedge and books the expected done cycles.
  task automatic start_run(input int id, input logic [23:0] junk, input int nruns);
    run_t r;
    for (int b = 0; b < 16; b++) key_mem[b] = keys[id][b];
    hi_junk = junk;
    clr = 1'b1;
    @(negedge ap_clk);
    clr = 1'b0;
    ap_start = 1'b1;
    for (int n = 0; n < nruns; n++) begin
      r.cyc    = ecnt + 228 + n * 229;
      r.key_id = id;
      exp_q.push_back(r);
    end
    if (nruns == 1) begin
      @(negedge ap_clk);
      ap_start = 1'b0;
    end
  endtask

  task automatic wait_runs(input int budget, input int drop_at);
    run_t e;
    for (int c = 0; c < budget && exp_q.size() != 0; c++) begin
      @(negedge ap_clk);
      clr = 1'b0;
      if (c == drop_at) ap_start = 1'b0;
      if (ap_done) begin
        e = exp_q.pop_front();
        check("done_cycle", ecnt, e.cyc);
        check("ap_ready", ap_ready, 1);
        check("we_pulses", wr_count, 176);
        check("dup_addr", dup_count, 0);
        check("bad_addr", bad_count, 0);
        foreach (vecs[v])
          if (vecs[v].key_id == e.key_id)
            check($sformatf("tbl[%0d]", vecs[v].addr), {24'd0, tbl[vecs[v].addr]}, {24'd0, vecs[v].exp});
        $display("run with key %0d done at cycle %0d", e.key_id, ecnt);
        clr = 1'b1;
      end
    end
    if (exp_q.size() != 0) begin
      check("run_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    @(negedge ap_clk);
    clr = 1'b0;
  endtask

  initial begin
    logic [127:0] fips_key;
    ap_rst   = 1'b1;
    ap_start = 1'b0;
    fips_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    for (int b = 0; b < 16; b++) begin
      keys[0][b] = fips_key[127 - 8*b -: 8];
      keys[1][b] = 8'h00;
    end

    add_vec(0, 0, 8'h2b);   add_vec(0, 120, 8'h7e); add_vec(0, 240, 8'h15); add_vec(0, 360, 8'h16);
    add_vec(0, 3, 8'h09);   add_vec(0, 123, 8'hcf); add_vec(0, 243, 8'h4f); add_vec(0, 363, 8'h3c);
    add_vec(0, 4, 8'ha0);   add_vec(0, 124, 8'hfa); add_vec(0, 244, 8'hfe); add_vec(0, 364, 8'h17);
    add_vec(0, 43, 8'hb6);  add_vec(0, 163, 8'h63); add_vec(0, 283, 8'h0c); add_vec(0, 403, 8'ha6);
    add_vec(1, 0, 8'h00);   add_vec(1, 120, 8'h00); add_vec(1, 240, 8'h00); add_vec(1, 360, 8'h00);
    add_vec(1, 4, 8'h62);   add_vec(1, 124, 8'h63); add_vec(1, 244, 8'h63); add_vec(1, 364, 8'h63);
    add_vec(1, 40, 8'hb4);  add_vec(1, 160, 8'hef); add_vec(1, 280, 8'h5b); add_vec(1, 400, 8'hcb);
    add_vec(1, 43, 8'h6f);  add_vec(1, 163, 8'h8f); add_vec(1, 283, 8'h18); add_vec(1, 403, 8'h8e);

    repeat (2) @(negedge ap_clk);
    check_reset_outputs("reset");
    clr = 1'b1;
    @(negedge ap_clk);
    clr = 1'b0;
    ap_rst = 1'b0;
    @(negedge ap_clk);

    // FIPS-197 key, with a stray start pulse while busy.
    start_run(0, 24'd0, 1);
    repeat (48) @(negedge ap_clk);
    check("busy_idle", ap_idle, 0);
    ap_start = 1'b1;
    @(negedge ap_clk);
    ap_start = 1'b0;
    wait_runs(400, -1);
    repeat (3) @(negedge ap_clk);
    check("idle_after_run", ap_idle, 1);
    check("no_rerun_key_ce", key_ce0, 0);

    // All-zero key.
    start_run(1, 24'd0, 1);
    wait_runs(400, -1);

    // Start held high across two back-to-back runs.
    start_run(0, 24'd0, 2);
    wait_runs(700, 300);

    // Reset mid-run, then a clean run.
    start_run(1, 24'd0, 1);
    repeat (98) @(negedge ap_clk);
    @(posedge ap_clk);
    #2 ap_rst = 1'b1;
    #1 check_reset_outputs("abort");
    exp_q.delete();
    @(negedge ap_clk);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    @(negedge ap_clk);
    check("post_abort_idle", ap_idle, 1);
    start_run(0, 24'd0, 1);
    wait_runs(400, -1);

    // Garbage in the upper key-memory bits must not matter.
    start_run(0, 24'($urandom) | 24'h000101, 1);
    wait_runs(400, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

endmodule
